output_port_allocator: RTL
==========================

// Module: output_port_allocator
// PURPOSE
// - Wormhole output-port allocator for one router output. It arbitrates among N_IN input buffers
//   whose front flit is routed to this port and locks the winner from head flit to tail flit.
// - It pops the winning buffer and forwards the flits downstream. Forwarding is gated by the
//   downstream on/off signal.
// - One instance per output port; sits between the input buffers and the crossbar/link register.
// PARAMETERS
// - N_IN    5   number of requesting input buffers (N,E,S,W,Local)
// - FLIT_W  64  flit width in bits
// PORTS
// - clk      in   1            single clock, all logic on posedge
// - rst_n    in   1            reset, synchronous, active-low
// - req_i    in   N_IN         req_i[k]: buffer k is non-empty and its front flit is routed here
// - flit_i   in   N_IN*FLIT_W  front flit of buffer k at flit_i[k*FLIT_W +: FLIT_W]
// - dn_on_i  in   1            downstream buffer on/off: 1 = may send, 0 = hold
// - pop_o    out  N_IN         one-hot or zero; pops buffer k this cycle (combinational)
// - flit_o   out  FLIT_W       registered forwarded flit
// - valid_o  out  1            flit_o valid this cycle
// - grant_o  out  N_IN         registered one-hot owner of the port; 0 when idle
// - busy_o   out  1            port locked to a packet
// BEHAVIOUR
// - Flit type field flit[63:62]: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
// - Reset (rst_n=0 at posedge): state=IDLE, grant_o=0, busy_o=0, valid_o=0, flit_o=0, rr_ptr=0.
//   pop_o=0 while rst_n=0.
// - Reset mid-packet abandons the lock; no tail is synthesised.
// - FSM has two states, IDLE and LOCKED.
// - IDLE:
//   - Eligible set e[k] = req_i[k] & type(flit_i[k]) in {HEAD, HEAD_TAIL}.
//   - If any e[k], the round-robin winner is the first set bit searching from rst_ptr upward, wrapping at N_IN-1 -> 0.
//   - Next cycle: state=LOCKED, grant_o=onehot(w), busy_o=1.
//   - No pop in IDLE, so there is 1 cycle of arbitration latency.
//   - Requesters whose front flit is BODY/TAIL are ignored; they are never granted from IDLE.
//   - Arbitration is independent of dn_on_i.
// - LOCKED (owner g):
//   - Transfer when req_i[g] & dn_on_i. Then pop_o[g]=1 in the same cycle.
//   - Next cycle: flit_o = flit_i[g] sampled at that edge, valid_o=1.
//   - No transfer in a cycle: pop_o=0, and next cycle valid_o=0 with flit_o holding its value.
//   - The lock is held across gaps (req_i[g]=0 or dn_on_i=0) indefinitely.
//   - Other requesters are never popped while locked.
//   - Transfer of a TAIL or HEAD_TAIL flit: next cycle state=IDLE, grant_o=0, busy_o=0, rr_ptr=(g+1) mod N_IN.
// - Throughput: 1 flit/cycle while locked. A packet of L flits occupies the port for L+1 cycles minimum.
// - A new arbitration may take place in the IDLE cycle immediately after a tail; there are no extra bubbles.
// - dn_on_i is sampled combinationally.
// - The downstream buffer's ON_OFF_DELAY=2 slack absorbs the in-flight flit and the registered output.
// - The allocator sends nothing when dn_on_i=0.
// - At most one bit of pop_o is ever set, and only pop_o[g] with req_i[g]=1.
//   A pop of an empty buffer never occurs.
// - Assertions:
//   - $onehot0(pop_o) and $onehot0(grant_o).
//   - pop_o != 0 implies state==LOCKED.
//   - A HEAD flit popped while LOCKED after the first flit is an error.
// STRUCTURE
// - noc_pkg (shared):
//   - FLIT_W;
//   - flit_type_t enum {BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11};
//   - FLIT_TYPE_MSB=63, FLIT_TYPE_LSB=62;
//   - function is_head(), is_tail();
//   - port index constants P_N..P_LOCAL.
// - Sub-module rr_arbiter #(N): combinational inputs req[N] and ptr[$clog2(N)]; output gnt one-hot.
//   It is reused by the VC and switch allocators.
// - The top level holds the FSM, the grant/rr_ptr registers, the pop logic and the output register.
// TESTING
// - Single packet:
//   - Stimulus: buffer 2 holds H,B,B,T; dn_on_i=1.
//   - Required: grant_o=5'b00100 from cycle 1; pop_o[2] in cycles 1-4; valid_o in cycles 2-5.
//   - Required: busy_o drops in cycle 5; rr_ptr becomes 3.
// - Round-robin fairness:
//   - Stimulus: inputs 0, 1 and 4 each hold one HEAD_TAIL flit, continuously refilled.
//   - Required: grant order is 0,1,4,0,1,4 with each grant lasting 1 LOCKED cycle.
// - Wormhole lock:
//   - Stimulus: input 1 is locked mid-packet; input 0 raises a HEAD.
//   - Required: pop_o[0]=0 until input 1's TAIL has transferred; then input 0 is granted. Flits never interleave.
// - Backpressure:
//   - Stimulus: dn_on_i=0 for 3 cycles in mid-packet.
//   - Required: pop_o=0 and valid_o=0 for those cycles; grant_o is unchanged.
//   - Required: the stream resumes with no loss or duplication; the flit sequence is compared against a scoreboard.
// - Gaps and non-head front:
//   - Stimulus: req_i[g] drops for 2 cycles mid-packet, and a BODY flit sits at the front of input 3 in IDLE.
//   - Required: the lock is held through the gap, and input 3 is never granted.
// - Reset mid-packet:
//   - Stimulus: rst_n=0 for 1 cycle while LOCKED.
//   - Required: next cycle grant_o=0, busy_o=0, valid_o=0, rr_ptr=0; pop_o=0 during reset.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router definitions: flit layout, flit type encoding, port indices and
// the allocator FSM state type.
package noc_pkg;

   localparam int FLIT_W        = 64;
   localparam int FLIT_TYPE_MSB = 63;
   localparam int FLIT_TYPE_LSB = 62;

   localparam int P_N     = 0;
   localparam int P_E     = 1;
   localparam int P_S     = 2;
   localparam int P_W     = 3;
   localparam int P_LOCAL = 4;

   typedef enum logic [1:0] {
      BODY      = 2'b00,
      HEAD      = 2'b01,
      TAIL      = 2'b10,
      HEAD_TAIL = 2'b11
   } flit_type_t;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } alloc_state_t;

   function automatic logic is_head(input flit_type_t t);
      return (t == HEAD) || (t == HEAD_TAIL);
   endfunction

   function automatic logic is_tail(input flit_type_t t);
      return (t == TAIL) || (t == HEAD_TAIL);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr_i,
// wrapping to index 0. Shared by the VC, switch and output-port allocators.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic [N-1:0] hi_mask;
   logic [N-1:0] req_hi;

   // Lowest set bit among requests at/above the pointer wins; otherwise the
   // lowest request overall, which is the wrapped search.
   always_comb begin
      hi_mask = '0;
      for (int k = 0; k < N; k++) begin
         hi_mask[k] = (k >= int'(ptr_i));
      end
      req_hi = req_i & hi_mask;
      if (|req_hi) begin
         gnt_o = req_hi & (~req_hi + N'(1));
      end else begin
         gnt_o = req_i & (~req_i + N'(1));
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: arbitrates among input buffers with a head flit
// at the front, locks the winner until its tail, pops it and registers the flits.
module output_port_allocator
   import noc_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int FLIT_W = noc_pkg::FLIT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_IN-1:0]        req_i,
   input  logic [N_IN*FLIT_W-1:0] flit_i,
   input  logic                   dn_on_i,
   output logic [N_IN-1:0]        pop_o,
   output logic [FLIT_W-1:0]      flit_o,
   output logic                   valid_o,
   output logic [N_IN-1:0]        grant_o,
   output logic                   busy_o
);

   localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

   alloc_state_t      state_q, state_d;
   logic [N_IN-1:0]   grant_q, grant_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [FLIT_W-1:0] flit_q, flit_d;
   logic              valid_q, valid_d;
   logic              mid_pkt_q, mid_pkt_d;

   logic [N_IN-1:0]   elig;
   logic [N_IN-1:0]   arb_gnt;
   logic [FLIT_W-1:0] own_flit;
   logic [PW-1:0]     own_idx;
   logic              own_req;
   logic              xfer;
   flit_type_t        own_type;

   // Only buffers presenting a head may start a packet; the owner's flit is
   // muxed with the one-hot grant.
   always_comb begin
      elig     = '0;
      own_flit = '0;
      own_idx  = '0;
      for (int k = 0; k < N_IN; k++) begin
         elig[k]  = req_i[k] & is_head(flit_type_t'(flit_i[k*FLIT_W + FLIT_TYPE_LSB +: 2]));
         own_flit = own_flit | (flit_i[k*FLIT_W +: FLIT_W] & {FLIT_W{grant_q[k]}});
         if (grant_q[k]) begin
            own_idx = PW'(k);
         end
      end
   end

   assign own_req  = |(req_i & grant_q);
   assign own_type = flit_type_t'(own_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
   assign xfer     = (state_q == S_LOCKED) && own_req && dn_on_i;
   assign pop_o    = (xfer && rst_n) ? grant_q : '0;

   rr_arbiter #(.N(N_IN), .PW(PW)) u_arb (
      .req_i (elig),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      flit_d    = flit_q;
      valid_d   = 1'b0;
      mid_pkt_d = mid_pkt_q;
      case (state_q)
         S_IDLE: begin
            if (|elig) begin
               state_d = S_LOCKED;
               grant_d = arb_gnt;
            end
         end
         S_LOCKED: begin
            if (xfer) begin
               valid_d   = 1'b1;
               flit_d    = own_flit;
               mid_pkt_d = 1'b1;
               if (is_tail(own_type)) begin
                  state_d   = S_IDLE;
                  grant_d   = '0;
                  mid_pkt_d = 1'b0;
                  rr_ptr_d  = (own_idx == PW'(N_IN - 1)) ? '0 : own_idx + PW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         flit_q    <= '0;
         valid_q   <= 1'b0;
         mid_pkt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         flit_q    <= flit_d;
         valid_q   <= valid_d;
         mid_pkt_q <= mid_pkt_d;
      end
   end

   assign flit_o  = flit_q;
   assign valid_o = valid_q;
   assign grant_o = grant_q;
   assign busy_o  = (state_q == S_LOCKED);

`ifndef SYNTHESIS
   a_pop_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop_o));
   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_o));
   a_pop_locked:   assert property (@(posedge clk) disable iff (!rst_n) (pop_o != '0) |-> (state_q == S_LOCKED));
   a_no_mid_head:  assert property (@(posedge clk) disable iff (!rst_n) (xfer && mid_pkt_q) |-> !is_head(own_type));
`endif

endmodule
